// File: rtl/cci_mpf_csrs_pkg.sv
// Shared definitions for the MPF CSR event counters: event index map and derived event count.
package cci_mpf_csrs_pkg;

  typedef enum logic [3:0] {
    CCI_MPF_CSR_EV_VTP_4KB_HIT,
    CCI_MPF_CSR_EV_VTP_4KB_MISS,
    CCI_MPF_CSR_EV_VTP_2MB_HIT,
    CCI_MPF_CSR_EV_VTP_2MB_MISS,
    CCI_MPF_CSR_EV_VTP_PT_WALK_BUSY,
    CCI_MPF_CSR_EV_VTP_FAILED_XLATE,
    CCI_MPF_CSR_EV_VC_MAP_CHANGE,
    CCI_MPF_CSR_EV_WRO_RR,
    CCI_MPF_CSR_EV_WRO_RW,
    CCI_MPF_CSR_EV_WRO_WR,
    CCI_MPF_CSR_EV_WRO_WW,
    CCI_MPF_CSR_EV_PWRITE
  } t_cci_mpf_csr_event_idx;

  localparam int CCI_MPF_CSR_NUM_EVENTS = int'(CCI_MPF_CSR_EV_PWRITE) + 1;

endpackage

// File: rtl/cci_mpf_csr_rd_fifo.sv
// Small synchronous FIFO buffering MMIO counter reads; a push is accepted when full if a pop happens in the same cycle.
module cci_mpf_csr_rd_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cci_mpf_csr_event_ctr.sv
// MPF shim event counter bank with buffered MMIO read responses.
// Optional build macro CCI_MPF_CSR_CTR_SATURATE_EN: counters saturate at all-ones instead of wrapping.
module cci_mpf_csr_event_ctr
  import cci_mpf_csrs_pkg::*;
#(
  parameter int NUM_EVENTS    = CCI_MPF_CSR_NUM_EVENTS,
  parameter int CTR_WIDTH     = 48,
  parameter int TID_WIDTH     = 9,
  parameter int RD_FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_EVENTS-1:0]         events,
  input  logic                          clr_valid,
  input  logic [NUM_EVENTS-1:0]         clr_mask,
  input  logic                          rd_req_valid,
  input  logic [$clog2(NUM_EVENTS)-1:0] rd_req_idx,
  input  logic [TID_WIDTH-1:0]          rd_req_tid,
  input  logic                          rsp_ready,
  output logic                          rsp_valid,
  output logic [TID_WIDTH-1:0]          rsp_tid,
  output logic [63:0]                   rsp_data,
  output logic                          rd_overflow
);

  localparam int IDX_W = $clog2(NUM_EVENTS);
  localparam int ENT_W = IDX_W + TID_WIDTH;

  logic [NUM_EVENTS-1:0] ev_q;
  logic [CTR_WIDTH-1:0]  ctr [NUM_EVENTS];
  logic [ENT_W-1:0]      head;
  logic [IDX_W-1:0]      head_idx;
  logic [TID_WIDTH-1:0]  head_tid;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic [CTR_WIDTH-1:0]  rd_val;

  function automatic logic [CTR_WIDTH-1:0] ctr_inc(input logic [CTR_WIDTH-1:0] v);
`ifdef CCI_MPF_CSR_CTR_SATURATE_EN
    ctr_inc = (&v) ? v : v + CTR_WIDTH'(1);
`else
    ctr_inc = v + CTR_WIDTH'(1);
`endif
  endfunction

  // Stage 0: register event pulses, then update counters from ev_q; clear wins over a same-cycle event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ev_q <= '0;
      for (int i = 0; i < NUM_EVENTS; i++) ctr[i] <= '0;
    end else begin
      ev_q <= events;
      for (int i = 0; i < NUM_EVENTS; i++) begin
        if (clr_valid && clr_mask[i]) ctr[i] <= '0;
        else if (ev_q[i])             ctr[i] <= ctr_inc(ctr[i]);
      end
    end
  end

  cci_mpf_csr_rd_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (RD_FIFO_DEPTH)
  ) u_rd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_req_valid),
    .push_data ({rd_req_idx, rd_req_tid}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign pop      = rsp_ready && !fifo_empty;
  assign head_idx = head[ENT_W-1:TID_WIDTH];
  assign head_tid = head[TID_WIDTH-1:0];

  always_comb begin
    rd_val = '0;
    if (int'(head_idx) < NUM_EVENTS) rd_val = ctr[head_idx];
  end

  // Stage 1: registered response captured in the pop cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid   <= 1'b0;
      rsp_tid     <= '0;
      rsp_data    <= '0;
      rd_overflow <= 1'b0;
    end else begin
      rsp_valid <= pop;
      if (pop) begin
        rsp_tid  <= head_tid;
        rsp_data <= 64'(rd_val);
      end
      if (rd_req_valid && fifo_full && !pop) rd_overflow <= 1'b1;
    end
  end

endmodule

// File: doc/cci_mpf_csr_event_ctr.md
# cci_mpf_csr_event_ctr

Counter bank and MMIO read sequencer for MPF shim event wires. Each single-cycle event pulse from the VTP, VC-map, WRO and PWRITE shims is summed into a private counter. Host MMIO reads of counters are buffered, because MMIO has no flow control, and then issued as read responses whenever the CCI response channel can take them. The block sits beside the MPF CSR manager, on the event side of the CSR interface.

## Interface
- NUM_EVENTS, 12: number of event inputs and counters.
- CTR_WIDTH, 48: counter width in bits, ≤ 64.
- TID_WIDTH, 9: MMIO transaction ID width.
- RD_FIFO_DEPTH, 4: read-request buffer entries, a power of 2.

- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- events  in  NUM_EVENTS  one-cycle event pulses, bit i increments counter i.
- clr_valid  in  1  clear strobe.
- clr_mask  in  NUM_EVENTS  counters cleared when clr_valid is high.
- rd_req_valid  in  1  MMIO counter read request; no back-pressure.
- rd_req_idx  in  $clog2(NUM_EVENTS)  counter index.
- rd_req_tid  in  TID_WIDTH  MMIO tid, echoed in the response.
- rsp_ready  in  1  the response channel may accept a response in the next cycle.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_tid  out  TID_WIDTH  echoed tid.
- rsp_data  out  64  counter value, zero-extended.
- rd_overflow  out  1  sticky flag: a request was dropped.

## Operation
- Event stage: events are registered into ev_q. A counter is updated from ev_q, one cycle after the pulse.
- Counter update, per counter i, evaluated each cycle:
  - If clr_valid && clr_mask[i], the counter becomes 0. A simultaneous ev_q[i] is dropped.
  - Else if ev_q[i], the counter increments by 1 (overflow handling is set under Configuration).
- Read FIFO: each cycle with rd_req_valid high pushes {idx, tid}.
  - A push while the FIFO is full and no pop happens in the same cycle is dropped, and rd_overflow is set.
  - A push and a pop in the same cycle on a full FIFO are both honoured.
  - rd_overflow clears only on reset.
- Issue: when the FIFO is non-empty and rsp_ready is high, the head is popped.
  - The next cycle has rsp_valid=1, rsp_tid=head tid, rsp_data=counter[head idx] as sampled in the pop cycle.
  - That sample includes any update committed at the end of the previous cycle.
- An index ≥ NUM_EVENTS returns rsp_data=0 and still produces a response.
- rsp_valid is never high for two consecutive cycles unless pops occurred in two consecutive cycles.
- Responses are returned in request order.
- Reset values: all counters 0, ev_q 0, FIFO empty, rsp_valid 0, rsp_tid 0, rsp_data 0, rd_overflow 0.
- Reset mid-operation: queued requests are discarded with no response.

## Timing
- Event pulse at cycle N: counter updated at the N+1 edge; a read popped in N+2 or later observes it.
- Read request at cycle N: FIFO non-empty in N+1. If rsp_ready is high in N+1, rsp_valid is high in N+2. Minimum latency is 2 cycles.
- Throughput: 1 response per cycle while rsp_ready stays high.
- rsp_ready low: no pop occurs, and the FIFO holds its contents indefinitely.
- All outputs are registered.

## Configuration
- CCI_MPF_CSR_CTR_SATURATE_EN:
  - Defined: a counter at all-ones (2^CTR_WIDTH−1) stays at that value on further events.
  - Undefined: counters wrap modulo 2^CTR_WIDTH.
  - Clear behaves the same in both cases.

## Structure
- cci_mpf_csrs_pkg holds:
  - the event-index enum t_cci_mpf_csr_event_idx (VTP 4KB hit/miss, 2MB hit/miss, PT-walk busy, failed translation, VC-map change, WRO RR/RW/WR/WW, PWRITE);
  - the derived NUM_EVENTS constant.
- One sub-module, cci_mpf_csr_rd_fifo: a synchronous FIFO with full, empty, push and pop. It must support simultaneous push and pop when full.

## Test plan
- Event counting: pulse events[3] for 5 cycles, wait 2 cycles, read idx 3 tid 0x1A → response at read+2 with rsp_tid=0x1A, rsp_data=5.
- Clear vs. event:
  - Counter 0 at 7; pulse events[0] in cycle N and assert clr_valid, clr_mask=1 in N+1 → counter 0 reads 0 (the event is dropped).
  - Clear with mask bit 0 low → counter 0 reads 8.
- Overflow and rsp_ready stall: hold rsp_ready=0, issue 5 back-to-back reads with tids 1–5 → rd_overflow=1. Raise rsp_ready → tids 1–4 return on 4 consecutive cycles; tid 5 never returns.
- Out-of-range index: read idx 15 with NUM_EVENTS=12 → rsp_data=0, tid echoed.
- Wrap and saturate: CTR_WIDTH=4, 17 events on one counter → reads 1 without the macro, 15 with CCI_MPF_CSR_CTR_SATURATE_EN.
- Reset mid-operation: assert reset with 3 requests queued and counters non-zero → no responses; rd_overflow=0; all counters read 0 afterwards.
